// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Divides clk down to a pixel tick and runs H/V counters over active,
// front porch, sync and back porch. Raster outputs delayed by 1+PIPE_DLY
// pixel ticks so sync/blank line up with colour fetched from memory.
// Ports:
//   clk, clear        system clock, synchronous active-high reset
//   rgb_in[7:0]       colour for the coordinate shown PIPE_DLY ticks earlier
//   pix_tick          one-clk pixel enable
//   hCount/vCount     raster counters (x/y while in the active area)
//   tile_col/row/x/y  glyph grid coordinates sliced from the counters
//   line_start        tick on which hCount wraps
//   frame_start       tick on which both counters wrap
//   hSync/vSync       delayed syncs, polarity set by HS_POL/VS_POL
//   bright, rgb       delayed active-video flag, blanked colour
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int CW        = 10,
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int TILE_LOG2 = 4,
    parameter int PIPE_DLY  = 0
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic [7:0]              rgb_in,
    output logic                    pix_tick,
    output logic [CW-1:0]           hCount,
    output logic [CW-1:0]           vCount,
    output logic [CW-TILE_LOG2-1:0] tile_col,
    output logic [CW-TILE_LOG2-1:0] tile_row,
    output logic [TILE_LOG2-1:0]    tile_x,
    output logic [TILE_LOG2-1:0]    tile_y,
    output logic                    line_start,
    output logic                    frame_start,
    output logic                    hSync,
    output logic                    vSync,
    output logic                    bright,
    output logic [7:0]              rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // At least one pipe slot so the array is never zero-sized.
    localparam int PD      = (PIPE_DLY > 0) ? PIPE_DLY : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef struct packed {
        logic hs;
        logic vs;
        logic br;
    } tim_t;

    logic [DW-1:0]    div_q, div_d;
    logic             tick_q, tick_d;
    logic [CW-1:0]    h_q, h_d;
    logic [CW-1:0]    v_q, v_d;
    tim_t             raw;
    tim_t             stage_out;
    tim_t [PD-1:0]    pipe_q, pipe_d;
    tim_t             out_q, out_d;
    logic [7:0]       rgb_q, rgb_d;

    // Divider: tick is registered, so the first tick lands CLK_DIV clks
    // after clear is released and is low during reset.
    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        tick_d = (div_q == DIV_LAST);
    end

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (tick_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_comb begin
        raw.hs = (h_q >= HS_BEG) && (h_q < HS_END);
        raw.vs = (v_q >= VS_BEG) && (v_q < VS_END);
        raw.br = (h_q < H_ACT) && (v_q < V_ACT);
    end

    assign stage_out = (PIPE_DLY == 0) ? raw : pipe_q[PD-1];

    always_comb begin
        pipe_d = pipe_q;
        out_d  = out_q;
        rgb_d  = rgb_q;
        if (tick_q) begin
            pipe_d[0] = raw;
            for (int i = 1; i < PD; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
            out_d = stage_out;
            // Colour is gated with the flag it is loaded alongside.
            rgb_d = stage_out.br ? rgb_in : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
            pipe_q <= '0;
            out_q  <= '0;
            rgb_q  <= 8'h00;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
            h_q    <= h_d;
            v_q    <= v_d;
            pipe_q <= pipe_d;
            out_q  <= out_d;
            rgb_q  <= rgb_d;
        end
    end

    assign pix_tick    = tick_q;
    assign hCount      = h_q;
    assign vCount      = v_q;
    assign tile_col    = h_q[CW-1:TILE_LOG2];
    assign tile_row    = v_q[CW-1:TILE_LOG2];
    assign tile_x      = h_q[TILE_LOG2-1:0];
    assign tile_y      = v_q[TILE_LOG2-1:0];
    assign line_start  = tick_q && (h_q == H_LAST);
    assign frame_start = line_start && (v_q == V_LAST);
    assign hSync       = out_q.hs ? HS_POL : ~HS_POL;
    assign vSync       = out_q.vs ? VS_POL : ~VS_POL;
    assign bright      = out_q.br;
    assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// Two instances: full 640x480 timing with PIPE_DLY=3, and a tiny raster.
module tb_vga_timing_gen;

    typedef struct packed {
        int         h;
        int         v;
        logic       hs;
        logic       vs;
        logic       br;
        logic [7:0] rgb;
        logic       ls;
        logic       fs;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected outputs after n pixel ticks since reset.
    function automatic rec_t model(input int n,
        input int ha, input int hf, input int hw, input int hb,
        input int va, input int vf, input int vw, input int vb,
        input int pd, input bit hp, input bit vp, input bit ramp);
        rec_t r;
        int ht, vt, ft, p, q, qh, qv, ph;
        bit ah, av, b;
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        ft = ht * vt;
        p = n % ft;
        r.h = p % ht;
        r.v = p / ht;
        r.ls = (r.h == ht - 1);
        r.fs = (p == ft - 1);
        ah = 0; av = 0; b = 0;
        if (n - 1 - pd >= 0) begin
            q  = (n - 1 - pd) % ft;
            qh = q % ht;
            qv = q / ht;
            ah = (qh >= ha + hf) && (qh < ha + hf + hw);
            av = (qv >= va + vf) && (qv < va + vf + vw);
            b  = (qh < ha) && (qv < va);
        end
        r.hs = ah ? hp : !hp;
        r.vs = av ? vp : !vp;
        r.br = b;
        ph = ((n - 1) % ft) % ht;
        r.rgb = !b ? 8'h00 : (ramp ? 8'(ph - pd) : 8'hE3);
        return r;
    endfunction

    // Instance A: default timing, CLK_DIV=2, PIPE_DLY=3
    logic       clr_a;
    logic [7:0] rin_a;
    logic       pt_a, ls_a, fs_a, hs_a, vs_a, br_a;
    logic [9:0] hc_a, vc_a;
    logic [5:0] tcol_a, trow_a;
    logic [3:0] tx_a, ty_a;
    logic [7:0] rgb_a;

    assign rin_a = 8'(hc_a - 10'd3);

    vga_timing_gen #(.CLK_DIV(2), .PIPE_DLY(3)) u_a (
        .clk(clk), .clear(clr_a), .rgb_in(rin_a),
        .pix_tick(pt_a), .hCount(hc_a), .vCount(vc_a),
        .tile_col(tcol_a), .tile_row(trow_a),
        .tile_x(tx_a), .tile_y(ty_a),
        .line_start(ls_a), .frame_start(fs_a),
        .hSync(hs_a), .vSync(vs_a), .bright(br_a), .rgb(rgb_a)
    );

    // Instance B: H 8/1/2/1, V 4/1/1/1, CLK_DIV=1, positive syncs
    logic       clr_b;
    logic [7:0] rin_b;
    logic       pt_b, ls_b, fs_b, hs_b, vs_b, br_b;
    logic [9:0] hc_b, vc_b;
    logic [7:0] tcol_b, trow_b;
    logic [1:0] tx_b, ty_b;
    logic [7:0] rgb_b;

    assign rin_b = 8'hE3;

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .TILE_LOG2(2), .PIPE_DLY(0)
    ) u_b (
        .clk(clk), .clear(clr_b), .rgb_in(rin_b),
        .pix_tick(pt_b), .hCount(hc_b), .vCount(vc_b),
        .tile_col(tcol_b), .tile_row(trow_b),
        .tile_x(tx_b), .tile_y(ty_b),
        .line_start(ls_b), .frame_start(fs_b),
        .hSync(hs_b), .vSync(vs_b), .bright(br_b), .rgb(rgb_b)
    );

    rec_t qa[$];
    rec_t qb[$];
    int   cyc_a = 0;
    int   cyc_b = 0;
    bit   run_a = 0;
    bit   run_b = 0;

    // Producers: push the expected record for each cycle that must tick.
    always @(posedge clk) begin
        #1;
        if (clr_a) begin
            cyc_a = 0;
            qa.delete();
        end else begin
            cyc_a++;
            if (cyc_a % 2 == 0)
                qa.push_back(model(cyc_a / 2 - 1, 640, 16, 96, 48,
                                   480, 10, 2, 33, 3, 0, 0, 1));
        end
    end

    always @(posedge clk) begin
        #1;
        if (clr_b) begin
            cyc_b = 0;
            qb.delete();
        end else begin
            cyc_b++;
            qb.push_back(model(cyc_b - 1, 8, 1, 2, 1,
                               4, 1, 1, 1, 0, 1, 1, 0));
        end
    end

    // Monitors: pop and compare whenever the DUT ticks.
    always @(negedge clk) begin
        rec_t r;
        if (run_a) begin
            cmp("a_tick", pt_a, int'(qa.size() != 0));
            if (qa.size() != 0) begin
                r = qa.pop_front();
                cmp("a_h", hc_a, r.h);
                cmp("a_v", vc_a, r.v);
                cmp("a_hs", hs_a, r.hs);
                cmp("a_vs", vs_a, r.vs);
                cmp("a_br", br_a, r.br);
                cmp("a_rgb", rgb_a, r.rgb);
                cmp("a_ls", ls_a, r.ls);
                cmp("a_fs", fs_a, r.fs);
                cmp("a_tcol", tcol_a, r.h >> 4);
                cmp("a_trow", trow_a, r.v >> 4);
                cmp("a_tx", tx_a, r.h % 16);
                cmp("a_ty", ty_a, r.v % 16);
            end else begin
                cmp("a_ls_idle", ls_a, 0);
                cmp("a_fs_idle", fs_a, 0);
            end
        end
    end

    always @(negedge clk) begin
        rec_t r;
        if (run_b) begin
            cmp("b_tick", pt_b, int'(qb.size() != 0));
            if (qb.size() != 0) begin
                r = qb.pop_front();
                cmp("b_h", hc_b, r.h);
                cmp("b_v", vc_b, r.v);
                cmp("b_hs", hs_b, r.hs);
                cmp("b_vs", vs_b, r.vs);
                cmp("b_br", br_b, r.br);
                cmp("b_rgb", rgb_b, r.rgb);
                cmp("b_ls", ls_b, r.ls);
                cmp("b_fs", fs_b, r.fs);
                cmp("b_tcol", tcol_b, r.h >> 2);
                cmp("b_trow", trow_b, r.v >> 2);
                cmp("b_tx", tx_b, r.h % 4);
                cmp("b_ty", ty_b, r.v % 4);
            end else begin
                cmp("b_ls_idle", ls_b, 0);
                cmp("b_fs_idle", fs_b, 0);
            end
        end
    end

    task automatic check_reset_a(input string nm);
        cmp({nm, "_pt"}, pt_a, 0);
        cmp({nm, "_h"}, hc_a, 0);
        cmp({nm, "_v"}, vc_a, 0);
        cmp({nm, "_br"}, br_a, 0);
        cmp({nm, "_rgb"}, rgb_a, 0);
        cmp({nm, "_hs"}, hs_a, 1);
        cmp({nm, "_vs"}, vs_a, 1);
    endtask

    task automatic check_reset_b(input string nm);
        cmp({nm, "_pt"}, pt_b, 0);
        cmp({nm, "_h"}, hc_b, 0);
        cmp({nm, "_v"}, vc_b, 0);
        cmp({nm, "_br"}, br_b, 0);
        cmp({nm, "_rgb"}, rgb_b, 0);
        cmp({nm, "_hs"}, hs_b, 0);
        cmp({nm, "_vs"}, vs_b, 0);
        cmp({nm, "_fs"}, fs_b, 0);
    endtask

    initial begin
        int k, lo, hi, nf, nh, nv, nb;
        clr_a = 1'b1;
        clr_b = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_a("a_rst");
        check_reset_b("b_rst");
        run_a = 1;
        run_b = 1;
        clr_a = 1'b0;
        clr_b = 1'b0;

        // A: reach (300,1) mid active line, then pulse clear.
        k = 0;
        while (!(pt_a && hc_a == 10'd300 && vc_a == 10'd1) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        cmp("a_reach_300_1", int'(k < 5000), 1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check_reset_a("a_clr");
        @(negedge clk);
        cmp("a_clr_c1_pt", pt_a, 0);
        @(negedge clk);
        cmp("a_clr_c2_pt", pt_a, 1);
        cmp("a_clr_c2_h", hc_a, 0);

        // A: one line = 1600 clk; 96 sync ticks, 640 bright ticks.
        lo = 0;
        hi = 0;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            if (!hs_a) lo++;
            if (br_a) hi++;
        end
        cmp("a_hs_low_clks", lo, 192);
        cmp("a_br_high_clks", hi, 1280);

        // B: 420 clk = 5 frames of 12x7.
        nf = 0; nh = 0; nv = 0; nb = 0;
        for (int i = 0; i < 420; i++) begin
            @(negedge clk);
            if (fs_b) nf++;
            if (hs_b) nh++;
            if (vs_b) nv++;
            if (br_b) nb++;
        end
        cmp("b_fs_count", nf, 5);
        cmp("b_hs_high_clks", nh, 70);
        cmp("b_vs_high_clks", nv, 60);
        cmp("b_br_high_clks", nb, 160);

        k = 0;
        while (!(pt_b && hc_b == 10'd6) && k < 50) begin
            @(negedge clk);
            k++;
        end
        cmp("b_reach_h6", int'(k < 50), 1);
        cmp("b_tcol_h6", tcol_b, 1);
        cmp("b_tx_h6", tx_b, 2);

        // B: clear mid-frame; first frame_start after a full 84 clk frame.
        repeat (20) @(negedge clk);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        check_reset_b("b_clr");
        nf = 0;
        for (int i = 0; i < 83; i++) begin
            @(negedge clk);
            if (fs_b) nf++;
        end
        cmp("b_no_early_fs", nf, 0);
        @(negedge clk);
        cmp("b_first_fs", fs_b, 1);
        cmp("b_first_ls", ls_b, 1);
        cmp("b_first_fs_h", hc_b, 11);
        cmp("b_first_fs_v", vc_b, 6);
        @(negedge clk);
        cmp("b_wrap_h", hc_b, 0);
        cmp("b_wrap_v", vc_b, 0);

        repeat (10) @(negedge clk);
        #1;
        cmp("a_queue_empty", qa.size(), 0);
        cmp("b_queue_empty", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Successor to the fixed 640x480 controller.
- Generates a pixel-tick enable from the system clock and drives H/V counters whose values are the active-area pixel coordinates.
- Provides tile (glyph) coordinates for glyph/world-memory lookup, and delays sync/blank through a programmable pipeline so they stay aligned with colour data fetched from memory.
- Sits between the display memory/BitGen-style colour logic and the VGA pins.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz); legal >= 1.
- CW, 10, counter/coordinate width.
- H_ACTIVE, 640, visible pixels per line.
- H_FRONT, 16, front porch (pixels).
- H_SYNC, 96, sync pulse (pixels).
- H_BACK, 48, back porch (pixels).
- V_ACTIVE, 480, visible lines.
- V_FRONT, 10, front porch (lines).
- V_SYNC, 2, sync pulse (lines).
- V_BACK, 33, back porch (lines).
- HS_POL, 0, active level of hSync.
- VS_POL, 0, active level of vSync.
- TILE_LOG2, 4, log2 of tile edge (16x16 glyphs -> 40x30 grid).
- PIPE_DLY, 0, extra pixel-tick delay on sync/bright/rgb to cover memory latency (0..7).

Ports:
- clk  in  1  system clock.
- clear  in  1  synchronous, active-high reset.
- rgb_in  in  8  colour (RRRGGGBB) for the coordinate presented PIPE_DLY pix_ticks earlier.
- pix_tick  out  1  one-clk pulse; all raster state advances only on it.
- hCount  out  CW  horizontal counter, 0..H_TOTAL-1; equals x while < H_ACTIVE.
- vCount  out  CW  vertical counter, 0..V_TOTAL-1; equals y while < V_ACTIVE.
- tile_col  out  CW-TILE_LOG2  hCount >> TILE_LOG2.
- tile_row  out  CW-TILE_LOG2  vCount >> TILE_LOG2.
- tile_x  out  TILE_LOG2  hCount low bits.
- tile_y  out  TILE_LOG2  vCount low bits.
- line_start  out  1  pulse when hCount wraps to 0.
- frame_start  out  1  pulse when both counters wrap to 0.
- hSync  out  1  horizontal sync, delayed and aligned.
- vSync  out  1  vertical sync, delayed and aligned.
- bright  out  1  active-video flag, delayed and aligned.
- rgb  out  8  blanked colour to DAC.

Behaviour:
- Definitions: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Counter order: active, front porch, sync, back porch.
- Divider: div counts 0..CLK_DIV-1. pix_tick = (div == CLK_DIV-1). With CLK_DIV=1, pix_tick is high every clk after reset.
- On pix_tick:
  - hCount increments; at H_TOTAL-1 it wraps to 0 and vCount advances.
  - vCount wraps at V_TOTAL-1 to 0.
  - Between ticks, everything holds.
- tile_* are combinational slices of hCount/vCount (latency 0).
- line_start and frame_start are asserted only in the clk where pix_tick occurs AND the counter is at its last value (i.e. the next state is 0). frame_start requires hCount == H_TOTAL-1 and vCount == V_TOTAL-1. They are one clk wide.
- Raw timing, computed from the current counters:
  - hs_raw active iff H_ACTIVE+H_FRONT <= hCount < H_ACTIVE+H_FRONT+H_SYNC.
  - vs_raw active iff V_ACTIVE+V_FRONT <= vCount < V_ACTIVE+V_FRONT+V_SYNC.
  - br_raw = (hCount < H_ACTIVE) && (vCount < V_ACTIVE).
- Pipeline (advances only on pix_tick):
  - hs_raw/vs_raw/br_raw pass through a PIPE_DLY-stage shift register, then an output register.
  - Total lag from a counter value to its hSync/vSync/bright = 1+PIPE_DLY pix_ticks.
  - rgb register loads (bright_next ? rgb_in : 8'h00) on the same pix_tick that bright loads bright_next. rgb is always 0 while bright = 0.
  - Polarity: hSync = hs_d ? HS_POL : ~HS_POL; vSync likewise with VS_POL.
- Reset (clear=1 at a clk edge, any time including mid-line or mid-pipeline):
  - div, hCount, vCount = 0; all pipeline stages flushed.
  - bright = 0, rgb = 0, pix_tick = 0, line_start = 0, frame_start = 0.
  - hSync = ~HS_POL, vSync = ~VS_POL (inactive).
  - First pix_tick occurs CLK_DIV clks after the clear is released.
  - No frame_start is issued for the initial (0,0) after reset.
- Counter values outside 0..TOTAL-1 are unreachable. No other inputs change timing.

Test Plan:
- Defaults, 2 full frames: hSync low for exactly 192 clk every 1600 clk; vSync low for 2 lines (3200 clk) every 840000 clk. First hSync falling edge follows the tick where hCount=656, by 1 pix_tick.
- Defaults: bright high for exactly 640 consecutive pix_ticks per line and 480 lines per frame; rgb_in=8'hE3 appears on rgb only while bright=1, else 8'h00.
- PIPE_DLY=3, rgb_in driven combinationally as hCount[7:0] delayed by 3 ticks: first active rgb of each line = 8'h00, then 8'h01... and bright rises 4 pix_ticks after hCount reaches 0.
- Small config (H 8/1/2/1, V 4/1/1/1, CLK_DIV=1, HS_POL=VS_POL=1): hSync high exactly at hCount 9..10 (+1 lag). frame_start pulses once per 12x7=84 clks. tile_col/tile_x with TILE_LOG2=2 at hCount=6: 1/2.
- Assert clear for 1 clk mid-active-line with PIPE_DLY=2: next clk bright=0, rgb=0, syncs inactive, hCount=vCount=0. Next pix_tick arrives after CLK_DIV clks; no frame_start until the full frame completes.
- Defaults: hCount=799, vCount=524 tick -> frame_start=1, line_start=1 in that clk; counters become 0/0.
